// File: rtl/data_mem_mmio.sv
// Data-side memory responder for the single-cycle MIPS core.
// Serves a word-addressed data RAM plus a small MMIO window at 0xFFFFFF00:
// LED register, 32-bit timer with compare/autoreload/irq, sticky status
// (match, fault) with write-1-to-clear, and a fault-address capture register.
module data_mem_mmio #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic        rd_en,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] led,
  output logic        irq
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) * 32'd4;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_COUNT  = 8'h04;
  localparam logic [7:0] OFF_CMP    = 8'h08;
  localparam logic [7:0] OFF_CTRL   = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_FADDR  = 8'h14;

  logic [31:0] ram_q [DEPTH_WORDS];

  logic [15:0] led_q,   led_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q,   cmp_d;
  logic [2:0]  ctrl_q,  ctrl_d;    // {irq_en, autoreload, en}
  logic        match_q, match_d;
  logic        fault_q, fault_d;
  logic [31:0] faddr_q, faddr_d;

  logic          is_ram, is_mmio, reg_hit, misal, bad, fault_ev, wr_ok, hit;
  logic [1:0]    w1c;
  logic [AW-1:0] ram_idx;
  logic [7:0]    off;

  // Address decode and fault qualification. Reads only count as accesses
  // when the core is actually loading (rd_en) and not storing.
  always_comb begin
    off      = aluout[7:0];
    ram_idx  = aluout[AW+1:2];
    is_ram   = aluout < RAM_BYTES;
    is_mmio  = aluout[31:8] == 24'hFFFFFF;
    reg_hit  = is_mmio && (off <= OFF_FADDR);
    misal    = |aluout[1:0];
    bad      = misal || !(is_ram || reg_hit);
    fault_ev = bad && (memwrite || rd_en);
    wr_ok    = memwrite && !bad;
  end

  // Combinational read mux; faulting addresses return 0.
  always_comb begin
    readdata = '0;
    if (!bad) begin
      if (is_ram) begin
        readdata = ram_q[ram_idx];
      end else begin
        case (off)
          OFF_LED:    readdata = {16'h0, led_q};
          OFF_COUNT:  readdata = count_q;
          OFF_CMP:    readdata = cmp_q;
          OFF_CTRL:   readdata = {29'h0, ctrl_q};
          OFF_STATUS: readdata = {30'h0, fault_q, match_q};
          OFF_FADDR:  readdata = faddr_q;
          default:    readdata = '0;
        endcase
      end
    end
  end

  // Next-state for the MMIO registers: timer step first, then CPU writes
  // override it; hardware set events win over same-cycle W1C.
  always_comb begin
    led_d   = led_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    faddr_d = faddr_q;
    w1c     = 2'b00;
    hit     = ctrl_q[0] && (count_q == cmp_q);

    if (ctrl_q[0]) count_d = (hit && ctrl_q[1]) ? 32'h0 : count_q + 32'd1;

    if (wr_ok && is_mmio) begin
      case (off)
        OFF_LED:    led_d   = writedata[15:0];
        OFF_COUNT:  count_d = writedata;
        OFF_CMP:    cmp_d   = writedata;
        OFF_CTRL:   ctrl_d  = writedata[2:0];
        OFF_STATUS: w1c     = writedata[1:0];
        default:    ;  // FAULT_ADDR is read-only; write silently dropped
      endcase
    end

    match_d = (match_q && !w1c[0]) || hit;
    fault_d = (fault_q && !w1c[1]) || fault_ev;
    if (fault_ev) faddr_d = aluout;
  end

  // MMIO register state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      ctrl_q  <= '0;
      match_q <= 1'b0;
      fault_q <= 1'b0;
      faddr_q <= '0;
    end else begin
      led_q   <= led_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
      fault_q <= fault_d;
      faddr_q <= faddr_d;
    end
  end

  // Data RAM write port; contents survive reset but reset blocks the store.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok && is_ram) ram_q[ram_idx] <= writedata;
  end

  assign led = led_q;
  assign irq = match_q && ctrl_q[2];

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed scenarios plus random
// traffic, all compared against a behavioural model of the register map.
module tb_data_mem_mmio;

  localparam logic [31:0] M = 32'hFFFFFF00;

  logic        clk = 1'b0;
  logic        rst, memwrite, rd_en;
  logic [31:0] aluout, writedata, readdata;
  logic [15:0] led;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  data_mem_mmio #(.DEPTH_WORDS(256)) dut (
    .clk(clk), .rst(rst), .memwrite(memwrite), .rd_en(rd_en),
    .aluout(aluout), .writedata(writedata), .readdata(readdata),
    .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [31:0] m_ram [256];
  bit        m_rv  [256];
  bit [15:0] m_led;
  bit [31:0] m_cnt, m_cmp, m_fa;
  bit [2:0]  m_ctl;
  bit        m_match, m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input bit [31:0] a);
    bit [7:0] o;
    o = a[7:0];
    if (a[1:0] != 2'b00) return 1'b0;
    if (a < 32'd1024) return 1'b1;
    return (a[31:8] == 24'hFFFFFF) && (o <= 8'h14);
  endfunction

  function automatic bit [31:0] exp_rd(input bit [31:0] a, output bit known);
    bit [7:0] o;
    known = 1'b1;
    o = a[7:0];
    if (!legal(a)) return 32'h0;
    if (a < 32'd1024) begin
      known = m_rv[a[9:2]];
      return m_ram[a[9:2]];
    end
    case (o)
      8'h00:   return {16'h0, m_led};
      8'h04:   return m_cnt;
      8'h08:   return m_cmp;
      8'h0C:   return {29'h0, m_ctl};
      8'h10:   return {30'h0, m_fault, m_match};
      default: return m_fa;
    endcase
  endfunction

  task automatic model_reset();
    m_led = 0; m_cnt = 0; m_cmp = 0; m_ctl = 0; m_match = 0; m_fault = 0; m_fa = 0;
  endtask

  task automatic model_edge(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit rd);
    bit ok, f, hit;
    bit [31:0] n_cnt;
    bit [1:0]  clr;
    bit [7:0]  o;
    o     = a[7:0];
    ok    = legal(a);
    f     = !ok && (we || rd);
    hit   = m_ctl[0] && (m_cnt == m_cmp);
    n_cnt = m_cnt;
    if (m_ctl[0]) n_cnt = (hit && m_ctl[1]) ? 32'h0 : m_cnt + 1;
    clr = 2'b00;
    if (we && ok) begin
      if (a < 32'd1024) begin
        m_ram[a[9:2]] = wd;
        m_rv[a[9:2]]  = 1'b1;
      end else begin
        case (o)
          8'h00: m_led = wd[15:0];
          8'h04: n_cnt = wd;
          8'h08: m_cmp = wd;
          8'h0C: m_ctl = wd[2:0];
          8'h10: clr   = wd[1:0];
          default: ;
        endcase
      end
    end
    m_match = (m_match && !clr[0]) || hit;
    m_fault = (m_fault && !clr[1]) || f;
    if (f) m_fa = a;
    m_cnt = n_cnt;
  endtask

  // One bus cycle: drive, sample mid-cycle, clock, update model.
  task automatic step(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit rd,
                      input bit cc = 1'b0, input bit [31:0] ce = 32'h0, input string tag = "");
    bit known;
    bit [31:0] e;
    rst = 1'b0; memwrite = we; aluout = a; writedata = wd; rd_en = rd;
    #2;
    e = exp_rd(a, known);
    if (known) chk("readdata", readdata, e);
    if (cc) chk(tag, readdata, ce);
    chk("led", {16'h0, led}, {16'h0, m_led});
    chk("irq", {31'h0, irq}, {31'h0, m_match & m_ctl[2]});
    @(posedge clk);
    model_edge(we, a, wd, rd);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1; memwrite = 1'b0; rd_en = 1'b0; aluout = 32'h0; writedata = 32'h0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit [31:0] a;
    int        r;
    bit [31:0] seq_ar [6];
    seq_ar = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};

    rst = 1'b1; memwrite = 1'b0; rd_en = 1'b0; aluout = 32'h0; writedata = 32'h0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;

    // Reset state
    step(0, M + 32'h04, 0, 1, 1, 32'h0, "rst_count");
    step(0, M + 32'h0C, 0, 1, 1, 32'h0, "rst_ctrl");
    step(0, M + 32'h10, 0, 1, 1, 32'h0, "rst_status");
    step(0, M + 32'h14, 0, 1, 1, 32'h0, "rst_faddr");

    // RAM store / load
    step(1, 32'h10,  32'hDEADBEEF, 0);
    step(1, 32'h3FC, 32'h12345678, 0);
    step(0, 32'h10,  0, 1, 1, 32'hDEADBEEF, "ram_10");
    step(0, 32'h3FC, 0, 1, 1, 32'h12345678, "ram_3fc");
    step(0, M + 32'h10, 0, 1, 1, 32'h0, "ram_status");

    // LED / CTRL masking
    step(1, M, 32'hFFFFFFFF, 0);
    chk("led_ff", {16'h0, led}, 32'h0000FFFF);
    step(0, M, 0, 1, 1, 32'h0000FFFF, "led_rd");
    step(1, M + 32'h0C, 32'hFFFFFFFF, 0);
    step(0, M + 32'h0C, 0, 1, 1, 32'h7, "ctrl_rd");

    // Timer autoreload with irq, and W1C vs. same-cycle match
    reset_pulse();
    step(1, M + 32'h08, 32'd3, 0);
    step(1, M + 32'h0C, 32'h7, 0);
    for (int i = 0; i < 6; i++) step(0, M + 32'h04, 0, 1, 1, seq_ar[i], "ar_count");
    chk("ar_irq_set", {31'h0, irq}, 32'h1);
    step(1, M + 32'h10, 32'h1, 0);           // count==2: clear wins
    chk("ar_w1c_clear", {31'h0, irq}, 32'h0);
    step(1, M + 32'h10, 32'h1, 0);           // count==3: match wins
    chk("ar_w1c_match", {31'h0, irq}, 32'h1);

    // Timer wrap without reload
    reset_pulse();
    step(1, M + 32'h04, 32'hFFFFFFFE, 0);
    step(1, M + 32'h08, 32'd5, 0);
    step(1, M + 32'h0C, 32'h1, 0);
    step(0, M + 32'h04, 0, 1, 1, 32'hFFFFFFFE, "wrap_fe");
    step(0, M + 32'h04, 0, 1, 1, 32'hFFFFFFFF, "wrap_ff");
    step(0, M + 32'h04, 0, 1, 1, 32'h00000000, "wrap_00");
    step(0, M + 32'h10, 0, 1, 1, 32'h0, "wrap_nomatch");
    for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 0);
    step(0, M + 32'h10, 0, 1, 1, 32'h1, "wrap_match");

    // Faults
    reset_pulse();
    step(1, 32'h12, 32'h11111111, 0);
    step(0, 32'h10, 0, 1, 1, 32'hDEADBEEF, "fault_ram_kept");
    step(0, M + 32'h10, 0, 1, 1, 32'h2, "fault_status");
    step(0, M + 32'h14, 0, 1, 1, 32'h12, "fault_addr1");
    step(0, 32'h00100000, 0, 1, 1, 32'h0, "fault_rd_zero");
    step(0, M + 32'h14, 0, 1, 1, 32'h00100000, "fault_addr2");
    step(1, M + 32'h10, 32'h2, 0);
    step(0, M + 32'h10, 0, 1, 1, 32'h0, "fault_w1c");

    // Reset mid-operation
    step(1, 32'h20, 32'h000055AA, 0);
    step(1, M, 32'h0000A5A5, 0);
    step(1, M + 32'h08, 32'd2, 0);
    step(1, M + 32'h0C, 32'h7, 0);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 0);
    chk("mid_irq", {31'h0, irq}, 32'h1);
    reset_pulse();
    chk("mid_led0", {16'h0, led}, 32'h0);
    chk("mid_irq0", {31'h0, irq}, 32'h0);
    step(0, M + 32'h04, 0, 1, 1, 32'h0, "mid_count0");
    step(0, M + 32'h04, 0, 1, 1, 32'h0, "mid_count_hold");
    step(0, 32'h20, 0, 1, 1, 32'h000055AA, "mid_ram_kept");

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        reset_pulse();
      end else begin
        case ($urandom_range(0, 4))
          0: a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
          1: a = 32'($urandom_range(0, 1023));
          2: a = M | {27'h0, 3'($urandom_range(0, 7)), 2'b00};
          3: a = M | 32'($urandom_range(0, 255));
          default: a = $urandom;
        endcase
        step($urandom_range(0, 2) == 0, a, $urandom, 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory responder for the single-cycle MIPS core. It answers the core's data port (`memwrite`, `aluout` as address, `writedata`, `readdata`) with a word-addressed data RAM and a small memory-mapped peripheral window. The window holds an LED register, a 32-bit timer with compare, sticky status and interrupt, and a fault-address capture register. It sits beside the core in the top level, opposite the instruction memory.

## Interface
- `DEPTH_WORDS`, 256: data RAM size in 32-bit words; a power of two, at most 16384.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `memwrite` input 1: store strobe from the core.
- `aluout` input 32: byte address from the core.
- `writedata` input 32: store data.
- `readdata` output 32: load data; combinational from the current address.
- `led` output 16: LED register bits [15:0].
- `irq` output 1: timer interrupt, `match & irq_en`.

## Operation
- Address decode:
  - RAM: `aluout < DEPTH_WORDS*4`; word index `aluout[31:2]`.
  - MMIO: `aluout[31:8] == 24'hFFFFFF`; register select `aluout[7:0]`.
  - Anything else is unmapped.
- MMIO map (all offsets word-aligned):
  - 0x00 LED: rw, bits [15:0]; reads zero-extended.
  - 0x04 COUNT: rw; a write loads the counter.
  - 0x08 CMP: rw compare value.
  - 0x0C CTRL: rw. bit0 `en`, bit1 `autoreload`, bit2 `irq_en`; other bits read 0.
  - 0x10 STATUS: bit0 `match`, bit1 `fault`; sticky; write-1-to-clear per bit.
  - 0x14 FAULT_ADDR: ro; last faulting address.
  - Any other MMIO offset is treated as unmapped.
- Faults:
  - Trigger: any access (read or write) with `aluout[1:0] != 0`, or any access to an unmapped address.
  - A read counts as an access only while `memwrite == 0`.
  - A fault sets `fault` and loads FAULT_ADDR with `aluout` on the next edge.
  - A faulting write has no other effect. A faulting read returns 0.
  - Read-side fault detection happens every cycle. The core drives `aluout` for non-memory instructions too, so fault capture on reads is qualified by an internal `rd_en` input. `rd_en` is tied to `memtoreg` at the top level.
- Timer:
  - While `en`: if `COUNT == CMP`, set `match`; the next COUNT is 0 when `autoreload`, otherwise `COUNT + 1`.
  - Otherwise COUNT increments modulo 2^32. 0xFFFFFFFF wraps to 0 with no flag unless CMP matched.
  - While `!en`, COUNT holds.
- Precedence:
  - A CPU write to COUNT beats increment and reload.
  - A hardware `match` set beats a same-cycle W1C of `match`.
  - A new fault beats a same-cycle W1C of `fault`.
  - Writes to FAULT_ADDR are ignored and do not fault.

## Timing
- Reads: `readdata` is valid combinationally in the same cycle as `aluout`. It shows RAM contents or MMIO register values as of the last edge.
- Writes: take effect on the rising edge where `memwrite == 1`. A read of the same address in the next cycle returns the new value.
- Reset, on the first edge with `rst == 1`: LED, COUNT, CMP, CTRL, STATUS and FAULT_ADDR are 0, so `led = 0` and `irq = 0`.
  - RAM contents are not reset.
  - `rst` overrides any same-cycle write or timer event.
  - Reset mid-count clears COUNT and `match` immediately.
- Latencies:
  - `irq` rises one cycle after the edge at which `COUNT == CMP` was sampled with `en` and `irq_en` set.
  - The timer has 1-cycle granularity. With CMP = N, loading COUNT = 0 and `en` on the same cycle asserts `match` N+1 edges later.

## Test plan
- RAM: store 0xDEADBEEF to 0x00000010, then store 0x12345678 to 0x000003FC (DEPTH_WORDS=256). Read back both: 0xDEADBEEF and 0x12345678; `fault` stays 0.
- LED/CTRL masking: write 0xFFFFFFFF to 0xFFFFFF00 → `led` = 0xFFFF; a read returns 0x0000FFFF. Write 0xFFFFFFFF to CTRL → a read returns 0x00000007.
- Timer autoreload with irq: CMP = 3, then CTRL = 0x7. COUNT sequence is 1, 2, 3, 0, 1, …; `match` sets, `irq` = 1. Writing 1 to STATUS clears `irq` unless that same cycle is a match cycle, in which case `irq` stays 1.
- Timer no-reload wrap: COUNT = 0xFFFFFFFE, CMP = 5, CTRL = 0x1 → COUNT goes 0xFFFFFFFF, then 0. `match` is set only after COUNT passes 5.
- Faults:
  - Store to 0x00000012 → RAM unchanged; STATUS = 0x2; FAULT_ADDR = 0x00000012.
  - Then load from 0x00100000 → `readdata` = 0; FAULT_ADDR = 0x00100000.
  - Then write 2 to STATUS → STATUS = 0.
- Reset mid-operation: timer running with `irq` = 1 and LED = 0xA5A5. Pulse `rst` for 1 cycle → `led` = 0, `irq` = 0, COUNT = 0 and holding. A RAM word written before reset still reads its old value.
